priv_issue_ctrl: RTL and testbench

Serialising controller for privileged instructions in the dual-issue backend. It sits between dispatch and the commit/ctrl stage. It tracks how many instructions are in flight, and when a privileged instruction (CSR, TLB, cache, counter, syscall, break, ertn, idle) reaches dispatch it does three things: drains the backend, issues that instruction alone in slot 0, and blocks all further issue until it commits. After commit it handles idle-wait and frontend refetch. It replaces the single-flop privileged-stall bit with an explicit FSM and in-flight counter.

---
 rtl/priv_issue_ctrl_pkg.sv | 24 ++
 rtl/priv_issue_ctrl_inflight_counter.sv | 64 ++++++
 rtl/priv_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_priv_issue_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/priv_issue_ctrl_pkg.sv
// Shared types and constants for the privileged-instruction issue controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package priv_issue_ctrl_pkg;

    // Default width of the backend in-flight counter.
    localparam int PRIV_INFLIGHT_W = 4;

    // Serialisation FSM states.
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        IDLE    = 3'd4,
        REFETCH = 3'd5
    } priv_ctrl_state_t;

    // Number of set bits in a two-slot mask.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/priv_issue_ctrl_inflight_counter.sv
// Saturating up/down count of instructions in flight, with a sticky error flag.
// Latency: registered count; the next-count value is also exported combinationally.
// Backpressure: none; an under- or overflow clamps the count and latches the error flag.
module priv_issue_ctrl_inflight_counter
    import priv_issue_ctrl_pkg::*;
#(
    parameter int INFLIGHT_W = PRIV_INFLIGHT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_fire,
    input  logic [1:0]            i_commit,
    input  logic                  i_clear,
    output logic [INFLIGHT_W-1:0] o_cnt,
    output logic [INFLIGHT_W-1:0] o_cnt_next,
    output logic                  o_err
);

    // Two extra bits: one for headroom above the maximum, one as a sign bit for underflow.
    localparam int SW = INFLIGHT_W + 2;
    localparam logic [SW-1:0] MAX_W = SW'((1 << INFLIGHT_W) - 1);

    logic [INFLIGHT_W-1:0] r_cnt;
    logic                  r_err;
    logic [SW-1:0]         w_sum;
    logic                  w_under;
    logic                  w_over;
    logic [INFLIGHT_W-1:0] w_cnt_next;

    assign w_sum   = {2'b00, r_cnt} + {{(SW-2){1'b0}}, popcount2(i_fire)}
                                    - {{(SW-2){1'b0}}, popcount2(i_commit)};
    assign w_under = w_sum[SW-1];
    assign w_over  = !w_under && (w_sum > MAX_W);

    // A flush clears the count outright; otherwise clamp at the range limits.
    always_comb begin
        w_cnt_next = w_sum[INFLIGHT_W-1:0];
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (w_under) begin
            w_cnt_next = '0;
        end else if (w_over) begin
            w_cnt_next = MAX_W[INFLIGHT_W-1:0];
        end
    end

    // The count follows its next value; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (!i_clear && (w_under || w_over)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_cnt_next;
    assign o_err      = r_err;

endmodule

// File: rtl/priv_issue_ctrl.sv
// Serialises privileged instructions: drains the backend, issues the instruction alone in slot 0, waits for its commit.
// Latency: issue_allow_o is combinational; state and status outputs update on the next clk edge.
// Backpressure: issue_allow_o withholds dispatch slots; pri_stall_o holds the frontend while not in RUN.
module priv_issue_ctrl
    import priv_issue_ctrl_pkg::*;
#(
    parameter int INFLIGHT_W = PRIV_INFLIGHT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            dispatch_valid_i,
    input  logic [1:0]            dispatch_is_pri_i,
    input  logic [1:0]            dispatch_fire_i,
    output logic [1:0]            issue_allow_o,
    input  logic [1:0]            commit_valid_i,
    input  logic                  commit_pri_i,
    input  logic                  commit_idle_i,
    input  logic                  commit_refetch_i,
    input  logic                  flush_i,
    input  logic                  int_pending_i,
    output logic                  pri_stall_o,
    output logic                  refetch_req_o,
    output logic                  idle_o,
    output logic [INFLIGHT_W-1:0] inflight_cnt_o,
    output logic                  cnt_err_o
);

    priv_ctrl_state_t      r_state;
    priv_ctrl_state_t      w_state_next;
    logic                  r_pri_stall;
    logic                  r_refetch;
    logic                  r_idle;
    logic                  w_p0;
    logic                  w_p1;
    logic [INFLIGHT_W-1:0] w_cnt_next;

    assign w_p0 = dispatch_valid_i[0] & dispatch_is_pri_i[0];
    assign w_p1 = dispatch_valid_i[1] & dispatch_is_pri_i[1];

    priv_issue_ctrl_inflight_counter #(
        .INFLIGHT_W (INFLIGHT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_fire     (dispatch_fire_i),
        .i_commit   (commit_valid_i),
        .i_clear    (flush_i),
        .o_cnt      (inflight_cnt_o),
        .o_cnt_next (w_cnt_next),
        .o_err      (cnt_err_o)
    );

    // Slot permission: a privileged slot 1 is held back until it reaches slot 0; nothing issues while in reset.
    always_comb begin
        issue_allow_o = 2'b00;
        if (rst) begin
            case (r_state)
                RUN:     issue_allow_o = {~w_p0 & ~w_p1, ~w_p0};
                ISSUE:   issue_allow_o = 2'b01;
                default: issue_allow_o = 2'b00;
            endcase
        end
    end

    // Next-state selection; a flush overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_p0) begin
                        w_state_next = (w_cnt_next == '0) ? ISSUE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_cnt_next == '0) begin
                        w_state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (dispatch_fire_i[0]) begin
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (commit_pri_i) begin
                        if (commit_idle_i) begin
                            w_state_next = IDLE;
                        end else if (commit_refetch_i) begin
                            w_state_next = REFETCH;
                        end else begin
                            w_state_next = RUN;
                        end
                    end
                end
                IDLE: begin
                    if (int_pending_i) begin
                        w_state_next = REFETCH;
                    end
                end
                REFETCH: w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_pri_stall <= 1'b0;
            r_refetch   <= 1'b0;
            r_idle      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pri_stall <= (w_state_next != RUN);
            r_refetch   <= (w_state_next == REFETCH);
            r_idle      <= (w_state_next == IDLE);
        end
    end

    assign pri_stall_o   = r_pri_stall;
    assign refetch_req_o = r_refetch;
    assign idle_o        = r_idle;

endmodule

// File: tb/tb_priv_issue_ctrl.sv
// Self-checking bench for priv_issue_ctrl: table-driven vectors with a scoreboard queue plus hand-written sequences.
// Latency: allow checked 1ns after inputs are driven; registered outputs checked 1ns after the rising edge.
// Backpressure: the bench drives dispatch_fire_i only within the allowed slots.
module tb_priv_issue_ctrl;

    typedef struct {
        logic [1:0] dv;
        logic [1:0] dp;
        logic [1:0] df;
        logic [1:0] cv;
        logic       cp;
        logic       ci;
        logic       cr;
        logic       fl;
        logic       ip;
        logic [1:0] allow;
        logic       stall;
        logic       rf;
        logic       idl;
        logic [3:0] cnt;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] dispatch_valid_i;
    logic [1:0] dispatch_is_pri_i;
    logic [1:0] dispatch_fire_i;
    logic [1:0] issue_allow_o;
    logic [1:0] commit_valid_i;
    logic       commit_pri_i;
    logic       commit_idle_i;
    logic       commit_refetch_i;
    logic       flush_i;
    logic       int_pending_i;
    logic       pri_stall_o;
    logic       refetch_req_o;
    logic       idle_o;
    logic [3:0] inflight_cnt_o;
    logic       cnt_err_o;

    int n_chk;
    int n_fail;
    vec_t sb_q[$];
    vec_t tbl[27];

    priv_issue_ctrl #(.INFLIGHT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_valid_i (dispatch_valid_i),
        .dispatch_is_pri_i(dispatch_is_pri_i),
        .dispatch_fire_i  (dispatch_fire_i),
        .issue_allow_o    (issue_allow_o),
        .commit_valid_i   (commit_valid_i),
        .commit_pri_i     (commit_pri_i),
        .commit_idle_i    (commit_idle_i),
        .commit_refetch_i (commit_refetch_i),
        .flush_i          (flush_i),
        .int_pending_i    (int_pending_i),
        .pri_stall_o      (pri_stall_o),
        .refetch_req_o    (refetch_req_o),
        .idle_o           (idle_o),
        .inflight_cnt_o   (inflight_cnt_o),
        .cnt_err_o        (cnt_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] dv, input logic [1:0] dp, input logic [1:0] df,
                                input logic [1:0] cv, input logic cp, input logic ci, input logic cr,
                                input logic fl, input logic ip, input logic [1:0] allow,
                                input logic stall, input logic rf, input logic idl,
                                input logic [3:0] cnt, input logic err);
        vec_t v;
        v.dv = dv; v.dp = dp; v.df = df; v.cv = cv; v.cp = cp; v.ci = ci; v.cr = cr;
        v.fl = fl; v.ip = ip; v.allow = allow; v.stall = stall; v.rf = rf; v.idl = idl;
        v.cnt = cnt; v.err = err;
        return v;
    endfunction

    // Drive one cycle of stimulus, check the combinational allow, queue and later compare the registered outputs.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        dispatch_valid_i  = v.dv;
        dispatch_is_pri_i = v.dp;
        dispatch_fire_i   = v.df;
        commit_valid_i    = v.cv;
        commit_pri_i      = v.cp;
        commit_idle_i     = v.ci;
        commit_refetch_i  = v.cr;
        flush_i           = v.fl;
        int_pending_i     = v.ip;
        sb_q.push_back(v);
        #1;
        chk({tag, ".allow"}, {6'd0, issue_allow_o}, {6'd0, v.allow});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".stall"}, {7'd0, pri_stall_o},   {7'd0, e.stall});
            chk({tag, ".refetch"}, {7'd0, refetch_req_o}, {7'd0, e.rf});
            chk({tag, ".idle"}, {7'd0, idle_o},        {7'd0, e.idl});
            chk({tag, ".cnt"}, {4'd0, inflight_cnt_o}, {4'd0, e.cnt});
            chk({tag, ".err"}, {7'd0, cnt_err_o},     {7'd0, e.err});
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b0;
        dispatch_valid_i  = 2'b00;
        dispatch_is_pri_i = 2'b00;
        dispatch_fire_i   = 2'b00;
        commit_valid_i    = 2'b00;
        commit_pri_i      = 1'b0;
        commit_idle_i     = 1'b0;
        commit_refetch_i  = 1'b0;
        flush_i           = 1'b0;
        int_pending_i     = 1'b0;

        //            dv     dp     df     cv     cp ci cr fl ip allow  st rf id cnt err
        // Build count to 3, then drain with one commit per cycle, issue, refetch commit.
        tbl[0]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd0, 0);
        tbl[1]  = mk(2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd2, 0);
        tbl[2]  = mk(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd3, 0);
        tbl[3]  = mk(2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd2, 0);
        tbl[4]  = mk(2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd1, 0);
        tbl[5]  = mk(2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd0, 0);
        tbl[6]  = mk(2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 4'd1, 0);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 1, 0, 0, 2'b00, 1, 1, 0, 4'd0, 0);
        tbl[8]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'd0, 0);
        // Slot-1 hold (fire and commit together keep count 0), then priv at slot 0 issues alone.
        tbl[9]  = mk(2'b11, 2'b10, 2'b01, 2'b01, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 4'd0, 0);
        tbl[10] = mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd0, 0);
        tbl[11] = mk(2'b11, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 4'd1, 0);
        tbl[12] = mk(2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'd0, 0);
        // commit_pri_i in RUN is ignored for state but still counted.
        tbl[13] = mk(2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd2, 0);
        tbl[14] = mk(2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 1, 0, 0, 2'b11, 0, 0, 0, 4'd1, 0);
        // Count to 5, enter DRAIN, flush.
        tbl[15] = mk(2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd3, 0);
        tbl[16] = mk(2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd5, 0);
        tbl[17] = mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd5, 0);
        tbl[18] = mk(2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd0, 0);
        // Idle commit with interrupt already pending: IDLE lasts one cycle; flush in REFETCH.
        tbl[19] = mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd0, 0);
        tbl[20] = mk(2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 4'd1, 0);
        tbl[21] = mk(2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 0, 0, 1, 2'b00, 1, 0, 1, 4'd0, 0);
        tbl[22] = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 4'd0, 0);
        tbl[23] = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd0, 0);
        // Underflow: two commits with count 1 clamps to 0 and latches the error.
        tbl[24] = mk(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd1, 0);
        tbl[25] = mk(2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd0, 1);
        tbl[26] = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 4'd0, 1);

        // Reset state, and allow forced low while in reset even though RUN would grant 11.
        #12;
        chk("rst.allow", {6'd0, issue_allow_o}, 8'd0);
        chk("rst.stall", {7'd0, pri_stall_o}, 8'd0);
        chk("rst.refetch", {7'd0, refetch_req_o}, 8'd0);
        chk("rst.idle", {7'd0, idle_o}, 8'd0);
        chk("rst.cnt", {4'd0, inflight_cnt_o}, 8'd0);
        chk("rst.err", {7'd0, cnt_err_o}, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // Idle wait with no interrupt for ten cycles, then an interrupt pulse wakes it.
        step(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd0, 1), "idl.pri");
        step(mk(2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 4'd1, 1), "idl.fire");
        step(mk(2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 4'd0, 1), "idl.commit");
        for (int i = 0; i < 9; i++) begin
            step(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 4'd0, 1),
                 $sformatf("idl.wait%0d", i));
        end
        step(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 4'd0, 1), "idl.wake");
        step(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'd0, 1), "idl.run");

        // Asynchronous reset in the middle of WAIT clears everything without a clock edge.
        step(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'd0, 1), "ar.pri");
        step(mk(2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 4'd1, 1), "ar.fire");
        @(negedge clk);
        dispatch_valid_i  = 2'b11;
        dispatch_is_pri_i = 2'b00;
        dispatch_fire_i   = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        chk("ar.allow", {6'd0, issue_allow_o}, 8'd0);
        chk("ar.stall", {7'd0, pri_stall_o}, 8'd0);
        chk("ar.refetch", {7'd0, refetch_req_o}, 8'd0);
        chk("ar.idle", {7'd0, idle_o}, 8'd0);
        chk("ar.cnt", {4'd0, inflight_cnt_o}, 8'd0);
        chk("ar.err", {7'd0, cnt_err_o}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar.allow_after", {6'd0, issue_allow_o}, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
